// File: rtl/shot_clock_ctrl.sv
// Shot-clock sequencer: one-second prescaler, load/run/stop control, expiry buzzer timing.
// Latency: PE/CET/D1/D0 registered (one cycle after the pulse); no backpressure, inputs are one-cycle pulses.
module shot_clock_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BUZZ_TICKS    = 2000
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       start,
  input  logic       stop,
  input  logic       load24,
  input  logic       load14,
  input  logic [3:0] num1,
  input  logic [3:0] num0,
  output logic       PE,
  output logic       CEP,
  output logic       CET,
  output logic [3:0] D1,
  output logic [3:0] D0,
  output logic       buzzer,
  output logic       running
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(BUZZ_TICKS + 1);
  localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [BW-1:0] BMAX = BW'(BUZZ_TICKS - 1);
  localparam logic [BW-1:0] BONE = BW'(1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_BUZZ} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic          zero, load, step;

  // Non-BCD digits are simply nonzero here, so they never trigger expiry.
  assign zero = (num1 == 4'd0) && (num0 == 4'd0);
  assign load = load24 | load14;

  always_comb begin
    state_n = state;
    presc_n = presc;
    bcnt_n  = '0;
    step    = 1'b0;
    case (state)
      ST_STOP: begin
        if (!load && start && !zero) state_n = ST_RUN;
      end
      ST_RUN: begin
        if (stop)               state_n = ST_STOP;
        else if (zero && !load) state_n = ST_BUZZ;
        if (presc == PMAX) begin
          presc_n = '0;
          step    = !zero && !load;
        end else begin
          presc_n = presc + PONE;
        end
      end
      ST_BUZZ: begin
        if (load || bcnt == BMAX) state_n = ST_STOP;
        else                      bcnt_n  = bcnt + BONE;
      end
      default: state_n = ST_STOP;
    endcase
    // Any reload restarts the partial second from zero.
    if (load) presc_n = '0;
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state <= ST_STOP;
      presc <= '0;
      bcnt  <= '0;
      PE    <= 1'b1;
      CET   <= 1'b0;
      D1    <= 4'd2;
      D0    <= 4'd4;
    end else begin
      state <= state_n;
      presc <= presc_n;
      bcnt  <= bcnt_n;
      PE    <= ~load;
      CET   <= step;
      if (load24) begin
        D1 <= 4'd2;
        D0 <= 4'd4;
      end else if (load14) begin
        D1 <= 4'd1;
        D0 <= 4'd4;
      end
    end
  end

  assign CEP     = (state == ST_RUN);
  assign running = (state == ST_RUN);
  assign buzzer  = (state == ST_BUZZ);

endmodule

// File: doc/shot_clock_ctrl.md
# shot_clock_ctrl

Run/stop and load sequencer for the 24-second shot-clock counter datapath (two cascaded BCD down-counters).
- Divides CP into one-second steps.
- Turns referee push-button pulses into counter load and count-enable strobes.
- Detects expiry from the counter's BCD outputs and times the expiry buzzer.
- Sits between the button debouncers and the counter/seven-segment datapath.

## Interface
Parameters:
- TICKS_PER_SEC, default 1000: CP cycles per counted second; must be ≥ 2.
- BUZZ_TICKS, default 2000: CP cycles the buzzer stays on after expiry; must be ≥ 1.

Ports:
- CP  in  1  clock; all state changes on the rising edge.
- CR  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse: run the clock.
- stop  in  1  one-cycle pulse: pause the clock.
- load24  in  1  one-cycle pulse: reload 24.
- load14  in  1  one-cycle pulse: reload 14.
- num1  in  4  datapath tens digit (BCD).
- num0  in  4  datapath units digit (BCD).
- PE  out  1  active-low synchronous parallel-load strobe to the datapath.
- CEP  out  1  count-enable level: high while running.
- CET  out  1  one-cycle step strobe; the datapath decrements on a CP edge when CEP and CET are both high.
- D1  out  4  load value, tens digit.
- D0  out  4  load value, units digit.
- buzzer  out  1  expiry horn.
- running  out  1  high in state RUN.

## Operation
- States: STOP, RUN, BUZZ. Reset state is STOP.
- zero = (num1 == 0 && num0 == 0). It is combinational from the inputs. Non-BCD digits count as nonzero.
- Prescaler: counts 0..TICKS_PER_SEC-1.
  - Advances only in RUN.
  - Holds in STOP and BUZZ, so a paused partial second resumes where it left off.
  - Clears to 0 on any load and on CR.
- Step: in RUN, when the prescaler is at TICKS_PER_SEC-1 and zero is false, CET is high for that one cycle and the prescaler wraps to 0. A step is never issued while zero is true, so the count never wraps 00→99.
- Load (load24 or load14):
  - PE low for exactly one cycle.
  - D1/D0 become 2/4 (load24) or 1/4 (load14) in that same cycle and hold afterwards.
  - CET forced low that cycle.
  - RUN stays RUN; STOP stays STOP; BUZZ goes to STOP with the buzzer cut.
- Transitions (evaluated each edge):
  - STOP→RUN on start when zero is false; start is ignored while zero is true.
  - RUN→STOP on stop.
  - RUN→BUZZ when zero is true and no load or stop is present that cycle.
  - BUZZ→STOP after BUZZ_TICKS cycles in BUZZ, or on a load. start and stop are ignored in BUZZ.
- Priority within one cycle: CR > load24 > load14 > stop > start.
  - load24 and load14 together: load24 wins.
  - stop and start together: stop wins.
  - A load and stop together: both take effect (load the value, end in STOP).
- Outputs:
  - CEP = running = (state == RUN).
  - buzzer = (state == BUZZ).
  - PE, CET, D1 and D0 are registered.

## Timing
- Reset values (cycle after CR is sampled high):
  - state STOP, prescaler 0, BUZZ counter 0.
  - PE = 1, CEP = 0, CET = 0, running = 0, buzzer = 0.
  - D1 = 2, D0 = 4.
- CR does not pulse PE. Reloading the datapath after reset is the user's job, via load24.
- A load pulse sampled at edge k gives PE = 0 during cycle k+1 only. The datapath shows the new count from cycle k+2.
- start sampled at edge k gives running = 1 from cycle k+1. With the prescaler at 0, the first CET arrives TICKS_PER_SEC cycles after entering RUN. CET is spaced exactly TICKS_PER_SEC cycles apart.
- Expiry sequence:
  - The CET that takes the count 01→00 is high in cycle j.
  - zero is visible in cycle j+1.
  - buzzer = 1 and running = 0 from cycle j+2.
  - buzzer = 0 again from cycle j+2+BUZZ_TICKS.
- PE = 0 and CET = 1 never occur in the same cycle.
- CR mid-RUN or mid-BUZZ: everything returns to reset values at the next edge. Any pending step or buzzer is dropped.

## Test plan
Use TICKS_PER_SEC = 4 and BUZZ_TICKS = 3, with a behavioural BCD down-counter datapath.
- Reset, then load24 → one PE low cycle, D1/D0 = 2/4, datapath shows 24, running = 0, no CET.
- start → CET every 4 cycles. The count runs 24, 23 … 01, 00. No CET at 00. buzzer high for exactly 3 cycles, starting 2 cycles after the final CET. Then STOP with the count at 00.
- stop after 2 prescaler cycles, wait 10 cycles, then start → the next CET arrives 2 cycles after running returns. The count is unchanged during the pause.
- In RUN at count 09, load14 → count 14 two cycles later, running stays 1, first new CET 4 cycles after the load cycle. load24 and load14 in the same cycle → D = 2/4.
- During BUZZ, start is ignored and load14 → buzzer drops next cycle, state STOP, count 14. start at count 00 in STOP is ignored.
- CR asserted during a CET cycle and during BUZZ → next cycle all outputs at reset values, and the datapath is not decremented by a later step.
